// File: rtl/fp_mul_arbiter_if.sv
// Client-side and unit-side signals of the shared multiplier arbiter.
// The arbiter connects through the slave modport; the client/unit side uses master.
interface fp_mul_arbiter_if #(
  parameter int DW   = 32,
  parameter int N_CH = 2
);
  localparam int OW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]          cli_req;
  logic [N_CH-1:0][DW-1:0]  cli_data1;
  logic [N_CH-1:0][DW-1:0]  cli_data2;
  logic [N_CH-1:0]          cli_ack;
  logic [N_CH-1:0]          cli_vld;
  logic [DW-1:0]            cli_result;
  logic                     cli_err;
  logic [DW-1:0]            unit_data1;
  logic [DW-1:0]            unit_data2;
  logic                     unit_trig;
  logic [DW-1:0]            unit_result;
  logic                     unit_vld;
  logic                     busy;
  logic [OW-1:0]            owner;

  modport master (
    output cli_req, cli_data1, cli_data2, unit_result, unit_vld,
    input  cli_ack, cli_vld, cli_result, cli_err, unit_data1, unit_data2,
           unit_trig, busy, owner
  );

  modport slave (
    input  cli_req, cli_data1, cli_data2, unit_result, unit_vld,
    output cli_ack, cli_vld, cli_result, cli_err, unit_data1, unit_data2,
           unit_trig, busy, owner
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one multi-cycle multiplier among N_CH clients,
// one op in flight, with an optional response timeout.
module fp_mul_arbiter #(
  parameter int DW      = 32,
  parameter int N_CH    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  fp_mul_arbiter_if.slave bus
);
  localparam int OW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   ptr_q, ptr_d, owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   d1_q, d1_d, d2_q, d2_d, res_q, res_d;
  logic            err_q, err_d, trig_q, trig_d;
  logic [N_CH-1:0] ack_q, ack_d, vld_q, vld_d;

  logic            found;
  logic [OW-1:0]   win, idx, nxt_ptr;
  logic            done_ok, done_to;

  // First requester at or after ptr, wrapping at N_CH.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = OW'((int'(ptr_q) + i) % N_CH);
      if (!found && bus.cli_req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign nxt_ptr = (owner_q == OW'(N_CH - 1)) ? '0 : owner_q + OW'(1);
  // trig_q marks the issue cycle, where a unit_vld cannot belong to this op.
  assign done_ok = (state_q == S_WAIT) && !trig_q && bus.unit_vld;
  assign done_to = (state_q == S_WAIT) && (TIMEOUT != 0) && (cnt_q == CNT_LAST) && !done_ok;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    res_d   = res_q;
    err_d   = err_q;
    trig_d  = 1'b0;
    ack_d   = '0;
    vld_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d     = S_WAIT;
          owner_d     = win;
          d1_d        = bus.cli_data1[win];
          d2_d        = bus.cli_data2[win];
          ack_d[win]  = 1'b1;
          trig_d      = 1'b1;
          cnt_d       = '0;
        end
      end
      S_WAIT: begin
        if (done_ok || done_to) begin
          state_d        = S_IDLE;
          res_d          = done_ok ? bus.unit_result : '0;
          err_d          = done_to;
          vld_d[owner_q] = 1'b1;
          ptr_d          = nxt_ptr;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      trig_q  <= 1'b0;
      ack_q   <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      res_q   <= res_d;
      err_q   <= err_d;
      trig_q  <= trig_d;
      ack_q   <= ack_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.cli_ack    = ack_q;
  assign bus.cli_vld    = vld_q;
  assign bus.cli_result = res_q;
  assign bus.cli_err    = err_q;
  assign bus.unit_data1 = d1_q;
  assign bus.unit_data2 = d2_q;
  assign bus.unit_trig  = trig_q;
  assign bus.busy       = (state_q == S_WAIT);
  assign bus.owner      = owner_q;
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench: 3-channel arbiter with TIMEOUT=8 against a transaction-level reference,
// plus a 2-channel TIMEOUT=0 instance for the long-latency case.
module tb_fp_mul_arbiter;
  localparam int NA    = 3;
  localparam int OWA   = 2;
  localparam int TOA   = 8;
  localparam int NEVER = 1000;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b1;
  always #5 sys_clk = ~sys_clk;

  fp_mul_arbiter_if #(.DW(32), .N_CH(NA)) a_if ();
  fp_mul_arbiter_if #(.DW(32), .N_CH(2))  b_if ();

  fp_mul_arbiter #(.DW(32), .N_CH(NA), .TIMEOUT(TOA)) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(a_if.slave));
  fp_mul_arbiter #(.DW(32), .N_CH(2), .TIMEOUT(0)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(b_if.slave));

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Truncating single-precision multiply (normal operands only) used as the unit.
  function automatic logic [31:0] unit_fn(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (p[47]) begin p = p >> 1; e = e + 10'd1; end
    return {a[31] ^ b[31], e[7:0], p[45:23]};
  endfunction

  // Reference: arbiter free/busy, rr pointer, age of the op in flight.
  bit                    m_busy;
  int                    m_ptr, m_own, m_age;
  logic [31:0]           m_d1, m_d2, m_res;
  bit                    m_err;
  // Inputs seen during the previous cycle.
  logic [NA-1:0]         p_req;
  logic [NA-1:0][31:0]   p_d1, p_d2;
  logic                  p_vld;
  logic [31:0]           p_res;
  // Unit model and bookkeeping.
  bit                    u_busy, hold;
  int                    u_cnt, u_lat, lat_lo = NEVER, lat_hi = NEVER;
  logic [31:0]           u_res;
  int                    cyc, t_trig, t_vld, t_uvld;
  int                    dut_grants[$];
  logic [NA-1:0]         ack_seen;

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_own = 0; m_age = 0;
    m_d1 = '0; m_d2 = '0; m_res = '0; m_err = 0; u_busy = 0;
  endtask

  task automatic model_step(output logic [NA-1:0] e_ack, output logic [NA-1:0] e_vld,
                            output bit e_trig);
    bit done;
    e_ack = '0; e_vld = '0; e_trig = 0; done = 0;
    if (!m_busy) begin
      for (int i = 0; i < NA; i++) begin
        int c = (m_ptr + i) % NA;
        if (p_req[OWA'(c)]) begin
          m_busy = 1; m_own = c; m_age = 0;
          e_ack[OWA'(c)] = 1'b1; e_trig = 1;
          m_d1 = p_d1[OWA'(c)]; m_d2 = p_d2[OWA'(c)];
          break;
        end
      end
    end else if (p_vld && m_age > 0) begin
      m_res = p_res; m_err = 0; done = 1;
    end else if (m_age == TOA - 1) begin
      m_res = '0; m_err = 1; done = 1;
    end else begin
      m_age++;
    end
    if (done) begin
      e_vld[OWA'(m_own)] = 1'b1;
      m_busy = 0;
      m_ptr  = (m_own + 1) % NA;
    end
  endtask

  task automatic step();
    logic [NA-1:0] e_ack, e_vld;
    bit            e_trig;
    p_req = a_if.cli_req; p_d1 = a_if.cli_data1; p_d2 = a_if.cli_data2;
    p_vld = a_if.unit_vld; p_res = a_if.unit_result;
    @(posedge sys_clk); #1;
    cyc++;
    if (!sys_rst_n) begin
      model_reset();
      chk("rst_quiet", 64'({a_if.cli_vld, a_if.cli_ack, a_if.unit_trig}), '0);
    end else begin
      model_step(e_ack, e_vld, e_trig);
      chk("ctl", 64'({a_if.cli_ack, a_if.cli_vld, a_if.unit_trig, a_if.busy, a_if.owner}),
                 64'({e_ack, e_vld, e_trig, m_busy, OWA'(m_own)}));
      chk("rsp", 64'({a_if.cli_err, a_if.cli_result}), 64'({m_err, m_res}));
      if (e_trig) chk("udata", {a_if.unit_data1, a_if.unit_data2}, {m_d1, m_d2});
    end
    if (a_if.unit_trig) t_trig = cyc;
    if (a_if.cli_vld != '0) t_vld = cyc;
    if (a_if.cli_ack != '0) begin
      dut_grants.push_back(int'(a_if.owner));
      ack_seen |= a_if.cli_ack;
    end
    if (!hold) a_if.cli_req &= ~a_if.cli_ack;
    a_if.unit_vld = 1'b0;
    if (a_if.unit_trig) begin
      u_busy = 1; u_cnt = 0;
      u_lat  = $urandom_range(lat_hi, lat_lo);
      u_res  = unit_fn(a_if.unit_data1, a_if.unit_data2);
    end else if (u_busy) begin
      u_cnt++;
    end
    if (u_busy && u_cnt == u_lat) begin
      a_if.unit_vld = 1'b1; a_if.unit_result = u_res; u_busy = 0; t_uvld = cyc;
    end
  endtask

  task automatic wait_vld(input string tag, input int lim);
    int n = 0;
    do begin step(); n++; end while (a_if.cli_vld == '0 && n < lim);
    chk({tag, "_seen"}, 64'(a_if.cli_vld != '0), 64'(1));
  endtask

  task automatic req(input int c, input logic [31:0] x, input logic [31:0] y);
    a_if.cli_req[OWA'(c)] = 1'b1; a_if.cli_data1[OWA'(c)] = x; a_if.cli_data2[OWA'(c)] = y;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] x, y;
    bit seen;
    int n;
    a_if.cli_req = '0; a_if.cli_data1 = '0; a_if.cli_data2 = '0;
    a_if.unit_vld = 1'b0; a_if.unit_result = '0;
    b_if.cli_req = '0; b_if.cli_data1 = '0; b_if.cli_data2 = '0;
    b_if.unit_vld = 1'b0; b_if.unit_result = '0;
    hold = 0; ack_seen = '0;
    model_reset();
    #2 sys_rst_n = 1'b0; #1;
    chk("reset_ctl", 64'({a_if.cli_ack, a_if.cli_vld, a_if.unit_trig, a_if.busy, a_if.owner, a_if.cli_err}), '0);
    chk("reset_dat", 64'({a_if.cli_result, a_if.unit_data1}), '0);
    chk("reset_b", 64'({b_if.cli_ack, b_if.cli_vld, b_if.unit_trig, b_if.busy, b_if.cli_result}), '0);
    step(); step();
    sys_rst_n = 1'b1;

    // Grant order with every channel held: 0,1,2,0,1,2.
    hold = 1; lat_lo = 1; lat_hi = 6;
    dut_grants.delete();
    for (int c = 0; c < NA; c++) req(c, $urandom, $urandom);
    for (n = 0; n < 300 && dut_grants.size() < 6; n++) step();
    chk("t2_cnt", 64'(dut_grants.size()), 64'(6));
    for (int i = 0; i < 6; i++)
      if (i < dut_grants.size()) chk("t2_order", 64'(dut_grants[i]), 64'(i % NA));
    hold = 0; a_if.cli_req = '0;
    wait_vld("t2_last", 20);
    step();

    // Single op on ch0, unit latency 5.
    lat_lo = 5; lat_hi = 5;
    req(0, 32'h3FC00000, 32'h40000000);
    step();
    chk("t1_ack", 64'(a_if.cli_ack), 64'(3'b001));
    chk("t1_trig", 64'(a_if.unit_trig), 64'(1));
    chk("t1_udata", {a_if.unit_data1, a_if.unit_data2}, {32'h3FC00000, 32'h40000000});
    wait_vld("t1", 20);
    chk("t1_res", 64'({a_if.cli_vld, a_if.cli_err, a_if.cli_result}), 64'({3'b001, 1'b0, 32'h40400000}));
    chk("t1_gap", 64'(t_vld - t_uvld), 64'(1));
    chk("t1_lat", 64'(t_vld - t_trig), 64'(6));

    // Unit never answers: timeout response 8 cycles after trig, then stray unit_vld.
    lat_lo = NEVER; lat_hi = NEVER;
    req(2, $urandom, $urandom);
    wait_vld("t3", 30);
    chk("t3_lat", 64'(t_vld - t_trig), 64'(TOA));
    chk("t3_rsp", 64'({a_if.cli_vld, a_if.cli_err, a_if.cli_result}), 64'({3'b100, 1'b1, 32'h0}));
    a_if.unit_vld = 1'b1; a_if.unit_result = $urandom;
    seen = 0;
    for (int i = 0; i < 4; i++) begin step(); if (a_if.cli_vld != '0) seen = 1; end
    chk("t3_stray", 64'(seen), 64'(0));

    // Unit answers on the last wait cycle: result wins over timeout.
    lat_lo = TOA - 1; lat_hi = TOA - 1;
    x = 32'h40490FDB; y = 32'h3F000000;
    req(1, x, y);
    wait_vld("t4", 30);
    chk("t4_lat", 64'(t_vld - t_trig), 64'(TOA));
    chk("t4_rsp", 64'({a_if.cli_vld, a_if.cli_err, a_if.cli_result}), 64'({3'b010, 1'b0, unit_fn(x, y)}));
    // One cycle later the unit is too late.
    lat_lo = TOA; lat_hi = TOA;
    req(0, $urandom, $urandom);
    wait_vld("t4b", 30);
    chk("t4b_err", 64'({a_if.cli_err, a_if.cli_result}), 64'({1'b1, 32'h0}));
    step(); step();

    // Short ch1 pulse while busy with ch0 is never granted.
    lat_lo = 6; lat_hi = 6; ack_seen = '0;
    req(0, $urandom, $urandom);
    step(); step(); step();
    req(1, $urandom, $urandom);
    step();
    a_if.cli_req[1] = 1'b0;
    wait_vld("t6", 20);
    step(); step(); step();
    chk("t6_noack1", 64'(ack_seen), 64'(3'b001));

    // TIMEOUT=0 instance with a 200-cycle unit: no error response.
    b_if.cli_req = 2'b01; b_if.cli_data1[0] = $urandom; b_if.cli_data2[0] = $urandom;
    n = 0;
    do begin step(); n++; end while (b_if.cli_ack == '0 && n < 10);
    chk("b_ack", 64'(b_if.cli_ack), 64'(2'b01));
    b_if.cli_req = '0; seen = 0;
    for (int i = 0; i < 200; i++) begin step(); if (b_if.cli_vld != '0) seen = 1; end
    chk("b_novld", 64'(seen), 64'(0));
    chk("b_busy", 64'(b_if.busy), 64'(1));
    b_if.unit_vld = 1'b1; b_if.unit_result = 32'h12345678;
    step();
    b_if.unit_vld = 1'b0;
    chk("b_rsp", 64'({b_if.cli_vld, b_if.cli_err, b_if.cli_result}), 64'({2'b01, 1'b0, 32'h12345678}));

    // Async reset mid-op, then ch1 alone gets the grant.
    lat_lo = NEVER; lat_hi = NEVER;
    req(0, $urandom, $urandom);
    step(); step(); step();
    #3 sys_rst_n = 1'b0; #1;
    chk("t5_ctl", 64'({a_if.cli_ack, a_if.cli_vld, a_if.unit_trig, a_if.busy, a_if.owner, a_if.cli_err}), '0);
    chk("t5_dat", 64'({a_if.unit_data1, a_if.unit_data2}), '0);
    a_if.cli_req = '0;
    model_reset();
    step(); step();
    sys_rst_n = 1'b1;
    lat_lo = 3; lat_hi = 3;
    req(1, $urandom, $urandom);
    step();
    chk("t5_ack1", 64'({a_if.cli_ack, a_if.owner}), 64'({3'b010, 2'd1}));
    wait_vld("t5", 20);

    // Random traffic, latencies 0..10 (0 and >=8 end in timeout).
    lat_lo = 0; lat_hi = 10;
    for (int i = 0; i < 500; i++) begin
      for (int c = 0; c < NA; c++)
        if (!a_if.cli_req[OWA'(c)] && $urandom_range(2, 0) == 0) req(c, $urandom, $urandom);
      hold = ($urandom_range(7, 0) == 0);
      step();
    end
    hold = 0;
    for (n = 0; n < 100 && (a_if.busy || a_if.cli_req != '0); n++) step();
    chk("drain", 64'({a_if.busy, a_if.cli_req}), '0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
